// File: rtl/traffic_pkg.sv
// Shared command-port definitions for the traffic light FSM and its command masters.
// Contents: command type width, data width, command code constants and a helper that
// flags reserved command types.
package traffic_pkg;

    localparam int unsigned CMD_TYPE_W = 3;
    localparam int unsigned CMD_DATA_W = 16;

    localparam logic [CMD_TYPE_W-1:0] CMD_ON          = 3'd0;
    localparam logic [CMD_TYPE_W-1:0] CMD_OFF         = 3'd1;
    localparam logic [CMD_TYPE_W-1:0] CMD_MANUAL_MODE = 3'd2;
    localparam logic [CMD_TYPE_W-1:0] CMD_SET_GREEN   = 3'd3;
    localparam logic [CMD_TYPE_W-1:0] CMD_SET_RED     = 3'd4;
    localparam logic [CMD_TYPE_W-1:0] CMD_SET_YELLOW  = 3'd5;

    // Codes above SET_YELLOW are reserved and never reach the light FSM.
    function automatic logic cmd_is_reserved(input logic [CMD_TYPE_W-1:0] cmd_type);
        return cmd_type > CMD_SET_YELLOW;
    endfunction

endpackage

// File: rtl/cmd_gap_timer.sv
// Minimum-idle-gap timer for a command-port master.
// Ports:
//   clk_i    - clock
//   srst_i   - synchronous active-high reset (counter cleared, gap satisfied)
//   load_i   - a command is being scheduled this cycle; reload the counter
//   gap_ok_o - counter has expired; the caller must still exclude a command it is
//              scheduling in the same cycle
module cmd_gap_timer #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic clk_i,
    input  logic srst_i,
    input  logic load_i,
    output logic gap_ok_o
);

    localparam int unsigned CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(GAP_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Loading at schedule time makes the count cover the emission cycle itself, so a
    // GAP_CYCLES of N leaves exactly N idle cycles between two commands.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign gap_ok_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_cfg_sequencer.sv
// Command-side controller in front of the traffic light FSM's single command port.
// Expands one reconfigure request into MANUAL_MODE, SET_GREEN, SET_RED, SET_YELLOW and an
// optional ON, shares the port with a host passthrough channel, enforces a minimum idle
// gap between commands and lets a host OFF abort a running sequence.
// Ports:
//   clk_i, srst_i            - clock, synchronous active-high reset
//   cfg_req_i / cfg_ready_o  - reconfigure request handshake
//   cfg_green/red/yellow_i   - phase times in cycles (zero is rejected)
//   cfg_auto_on_i            - append ON after SET_YELLOW
//   cfg_done_o / cfg_err_o   - one-cycle completion / reject-or-abort pulses
//   host_cmd_*               - host passthrough channel (ready is combinational)
//   cmd_type/valid/data_o    - registered command port to the light FSM
module traffic_cfg_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned CMD_GAP_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  cfg_req_i,
    output logic                  cfg_ready_o,
    input  logic [CMD_DATA_W-1:0] cfg_green_i,
    input  logic [CMD_DATA_W-1:0] cfg_red_i,
    input  logic [CMD_DATA_W-1:0] cfg_yellow_i,
    input  logic                  cfg_auto_on_i,
    output logic                  cfg_done_o,
    output logic                  cfg_err_o,
    input  logic [CMD_TYPE_W-1:0] host_cmd_type_i,
    input  logic                  host_cmd_valid_i,
    input  logic [CMD_DATA_W-1:0] host_cmd_data_i,
    output logic                  host_cmd_ready_o,
    output logic [CMD_TYPE_W-1:0] cmd_type_o,
    output logic                  cmd_valid_o,
    output logic [CMD_DATA_W-1:0] cmd_data_o
);

    typedef enum logic [2:0] {
        StIdle,
        StSeqManual,
        StSeqGreen,
        StSeqRed,
        StSeqYellow,
        StSeqOn
    } state_e;

    state_e                state_q, state_d;
    logic [CMD_DATA_W-1:0] green_q, red_q, yellow_q;
    logic                  auto_on_q;
    logic                  cmd_valid_q, cmd_valid_d;
    logic [CMD_TYPE_W-1:0] cmd_type_q, cmd_type_d;
    logic [CMD_DATA_W-1:0] cmd_data_q, cmd_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  latch_cfg;
    logic                  gap_ok;
    logic                  host_ready;
    logic                  host_rsvd, host_off, host_emit;
    logic                  cfg_bad;
    logic                  last_step;
    logic [CMD_TYPE_W-1:0] seq_type;
    logic [CMD_DATA_W-1:0] seq_data;
    state_e                seq_next;

    cmd_gap_timer #(
        .GAP_CYCLES(CMD_GAP_CYCLES)
    ) u_gap_timer (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .load_i  (cmd_valid_d),
        .gap_ok_o(gap_ok)
    );

    assign host_rsvd = cmd_is_reserved(host_cmd_type_i);
    assign host_off  = (host_cmd_type_i == CMD_OFF);
    assign cfg_bad   = (cfg_green_i == '0) || (cfg_red_i == '0) || (cfg_yellow_i == '0);
    assign last_step = (state_q == StSeqOn) || ((state_q == StSeqYellow) && !auto_on_q);

    // Command owned by the current sequence state and the state that follows it.
    always_comb begin
        seq_type = CMD_ON;
        seq_data = '0;
        seq_next = StIdle;
        unique case (state_q)
            StSeqManual: begin
                seq_type = CMD_MANUAL_MODE;
                seq_next = StSeqGreen;
            end
            StSeqGreen: begin
                seq_type = CMD_SET_GREEN;
                seq_data = green_q;
                seq_next = StSeqRed;
            end
            StSeqRed: begin
                seq_type = CMD_SET_RED;
                seq_data = red_q;
                seq_next = StSeqYellow;
            end
            StSeqYellow: begin
                seq_type = CMD_SET_YELLOW;
                seq_data = yellow_q;
                seq_next = auto_on_q ? StSeqOn : StIdle;
            end
            StSeqOn: begin
                seq_type = CMD_ON;
                seq_next = StIdle;
            end
            default: begin
                seq_type = CMD_ON;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cmd_valid_d = 1'b0;
        cmd_type_d  = '0;
        cmd_data_d  = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        latch_cfg   = 1'b0;
        host_ready  = 1'b0;
        host_emit   = 1'b0;

        if (state_q == StIdle) begin
            host_ready = gap_ok;
            host_emit  = host_cmd_valid_i && gap_ok && !host_rsvd;
            if (host_cmd_valid_i && gap_ok && host_rsvd) begin
                err_d = 1'b1;
            end
            if (host_emit) begin
                cmd_valid_d = 1'b1;
                cmd_type_d  = host_cmd_type_i;
                cmd_data_d  = host_cmd_data_i;
            end
            if (cfg_req_i) begin
                if (cfg_bad) begin
                    err_d = 1'b1;
                end else begin
                    latch_cfg = 1'b1;
                    // MANUAL_MODE goes out at once unless the host owns this cycle.
                    if (gap_ok && !host_emit) begin
                        cmd_valid_d = 1'b1;
                        cmd_type_d  = CMD_MANUAL_MODE;
                        state_d     = StSeqGreen;
                    end else begin
                        state_d = StSeqManual;
                    end
                end
            end
        end else begin
            host_ready = host_off || host_rsvd;
            if (host_cmd_valid_i && host_off) begin
                // Abort: OFF bypasses the gap.
                cmd_valid_d = 1'b1;
                cmd_type_d  = host_cmd_type_i;
                cmd_data_d  = host_cmd_data_i;
                err_d       = 1'b1;
                state_d     = StIdle;
            end else begin
                if (host_cmd_valid_i && host_rsvd) begin
                    err_d = 1'b1;
                end
                // The final state is held through its emission cycle so cfg_ready_o
                // only rises once cfg_done_o has been seen.
                if (last_step && done_q) begin
                    state_d = StIdle;
                end else if (gap_ok) begin
                    cmd_valid_d = 1'b1;
                    cmd_type_d  = seq_type;
                    cmd_data_d  = seq_data;
                    if (last_step) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = seq_next;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q     <= StIdle;
            green_q     <= '0;
            red_q       <= '0;
            yellow_q    <= '0;
            auto_on_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_type_q  <= '0;
            cmd_data_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_type_q  <= cmd_type_d;
            cmd_data_q  <= cmd_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
            if (latch_cfg) begin
                green_q   <= cfg_green_i;
                red_q     <= cfg_red_i;
                yellow_q  <= cfg_yellow_i;
                auto_on_q <= cfg_auto_on_i;
            end
        end
    end

    assign cfg_ready_o      = (state_q == StIdle);
    assign host_cmd_ready_o = host_ready;
    assign cmd_valid_o      = cmd_valid_q;
    assign cmd_type_o       = cmd_type_q;
    assign cmd_data_o       = cmd_data_q;
    assign cfg_done_o       = done_q;
    assign cfg_err_o        = err_q;

endmodule

// File: tb/tb_traffic_cfg_sequencer.sv
// Self-checking bench for traffic_cfg_sequencer: a host-passthrough vector table plus
// hand-written multi-cycle sequences (full reconfigure, reject, abort, blocked host
// command, simultaneous host/cfg, reset mid-sequence).
module tb_traffic_cfg_sequencer;
    import traffic_pkg::*;

    localparam int unsigned GAP = 2;

    logic        clk = 1'b0;
    logic        srst;
    logic        cfg_req;
    logic        cfg_ready;
    logic [15:0] cfg_green, cfg_red, cfg_yellow;
    logic        cfg_auto_on;
    logic        cfg_done, cfg_err;
    logic [2:0]  host_type;
    logic        host_valid;
    logic [15:0] host_data;
    logic        host_ready;
    logic [2:0]  cmd_type;
    logic        cmd_valid;
    logic [15:0] cmd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    traffic_cfg_sequencer #(
        .CMD_GAP_CYCLES(GAP)
    ) dut (
        .clk_i           (clk),
        .srst_i          (srst),
        .cfg_req_i       (cfg_req),
        .cfg_ready_o     (cfg_ready),
        .cfg_green_i     (cfg_green),
        .cfg_red_i       (cfg_red),
        .cfg_yellow_i    (cfg_yellow),
        .cfg_auto_on_i   (cfg_auto_on),
        .cfg_done_o      (cfg_done),
        .cfg_err_o       (cfg_err),
        .host_cmd_type_i (host_type),
        .host_cmd_valid_i(host_valid),
        .host_cmd_data_i (host_data),
        .host_cmd_ready_o(host_ready),
        .cmd_type_o      (cmd_type),
        .cmd_valid_o     (cmd_valid),
        .cmd_data_o      (cmd_data)
    );

    typedef struct {
        logic [2:0]  t;
        logic [15:0] d;
        logic        exp_valid;
        logic        exp_err;
    } host_vec_t;

    typedef struct {
        int          cyc;
        logic [2:0]  t;
        logic [15:0] d;
        logic        done;
    } ev_t;

    host_vec_t vecs[6];
    ev_t       ev_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_cfg(input logic [15:0] g, input logic [15:0] r, input logic [15:0] y,
                             input logic a);
        cfg_req     = 1'b1;
        cfg_green   = g;
        cfg_red     = r;
        cfg_yellow  = y;
        cfg_auto_on = a;
    endtask

    // Caller has set up inputs in cycle N; checks cycles N+1..N+len against ev_q.
    task automatic check_window(input string tag, input int len, input int ready_from);
        for (int k = 1; k <= len; k++) begin
            bit hit;
            int idx;
            tick();
            if (k == 1) begin
                cfg_req    = 1'b0;
                host_valid = 1'b0;
            end
            hit = 1'b0;
            idx = 0;
            foreach (ev_q[i]) begin
                if (ev_q[i].cyc == k) begin
                    hit = 1'b1;
                    idx = i;
                end
            end
            chk({tag, "_valid"}, cmd_valid, hit);
            chk({tag, "_done"}, cfg_done, hit ? ev_q[idx].done : 1'b0);
            chk({tag, "_err"}, cfg_err, 0);
            chk({tag, "_ready"}, cfg_ready, (k >= ready_from) ? 1 : 0);
            if (hit) begin
                chk({tag, "_type"}, cmd_type, ev_q[idx].t);
                chk({tag, "_data"}, cmd_data, ev_q[idx].d);
            end
        end
    endtask

    initial begin
        vecs[0] = '{t: CMD_SET_GREEN,  d: 16'h1234, exp_valid: 1'b1, exp_err: 1'b0};
        vecs[1] = '{t: CMD_OFF,        d: 16'h0000, exp_valid: 1'b1, exp_err: 1'b0};
        vecs[2] = '{t: 3'd7,           d: 16'hBEEF, exp_valid: 1'b0, exp_err: 1'b1};
        vecs[3] = '{t: 3'd6,           d: 16'h0001, exp_valid: 1'b0, exp_err: 1'b1};
        vecs[4] = '{t: CMD_SET_YELLOW, d: 16'h00FF, exp_valid: 1'b1, exp_err: 1'b0};
        vecs[5] = '{t: CMD_ON,         d: 16'hA5A5, exp_valid: 1'b1, exp_err: 1'b0};

        srst = 1'b1; cfg_req = 1'b0; cfg_green = '0; cfg_red = '0; cfg_yellow = '0;
        cfg_auto_on = 1'b0; host_type = '0; host_valid = 1'b0; host_data = '0;

        // Reset state
        tick();
        tick();
        chk("rst_valid", cmd_valid, 0);
        chk("rst_type", cmd_type, 0);
        chk("rst_data", cmd_data, 0);
        chk("rst_done", cfg_done, 0);
        chk("rst_err", cfg_err, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        chk("rst_host_ready", host_ready, 1);
        srst = 1'b0;
        tick();

        // Host passthrough table in IDLE
        for (int i = 0; i < 6; i++) begin
            repeat (3) tick();
            host_type  = vecs[i].t;
            host_data  = vecs[i].d;
            host_valid = 1'b1;
            #1;
            chk("tbl_host_ready", host_ready, 1);
            tick();
            host_valid = 1'b0;
            chk("tbl_valid", cmd_valid, vecs[i].exp_valid);
            chk("tbl_type", cmd_type, vecs[i].exp_valid ? vecs[i].t : 3'd0);
            chk("tbl_data", cmd_data, vecs[i].exp_valid ? vecs[i].d : 16'd0);
            chk("tbl_err", cfg_err, vecs[i].exp_err);
        end

        // Full sequence with auto ON
        repeat (3) tick();
        start_cfg(16'd20, 16'd30, 16'd5, 1'b1);
        #1;
        chk("seq_ready_n", cfg_ready, 1);
        ev_q.delete();
        ev_q.push_back('{cyc: 1,  t: CMD_MANUAL_MODE, d: 16'd0,  done: 1'b0});
        ev_q.push_back('{cyc: 4,  t: CMD_SET_GREEN,   d: 16'd20, done: 1'b0});
        ev_q.push_back('{cyc: 7,  t: CMD_SET_RED,     d: 16'd30, done: 1'b0});
        ev_q.push_back('{cyc: 10, t: CMD_SET_YELLOW,  d: 16'd5,  done: 1'b0});
        ev_q.push_back('{cyc: 13, t: CMD_ON,          d: 16'd0,  done: 1'b1});
        check_window("seq", 15, 14);

        // Reject: yellow == 0
        repeat (3) tick();
        start_cfg(16'd20, 16'd30, 16'd0, 1'b1);
        tick();
        cfg_req = 1'b0;
        chk("rej_valid", cmd_valid, 0);
        chk("rej_err", cfg_err, 1);
        chk("rej_ready", cfg_ready, 1);
        tick();
        chk("rej_err_pulse", cfg_err, 0);
        chk("rej_valid2", cmd_valid, 0);
        chk("rej_ready2", cfg_ready, 1);

        // Host OFF abort after SET_GREEN
        repeat (3) tick();
        start_cfg(16'd7, 16'd8, 16'd9, 1'b1);
        tick();
        cfg_req = 1'b0;
        chk("abt_manual", cmd_type, CMD_MANUAL_MODE);
        repeat (3) tick();
        chk("abt_green_valid", cmd_valid, 1);
        chk("abt_green_type", cmd_type, CMD_SET_GREEN);
        chk("abt_green_data", cmd_data, 7);
        tick();
        host_type  = CMD_OFF;
        host_data  = 16'd0;
        host_valid = 1'b1;
        #1;
        chk("abt_host_ready", host_ready, 1);
        tick();
        host_valid = 1'b0;
        chk("abt_off_valid", cmd_valid, 1);
        chk("abt_off_type", cmd_type, CMD_OFF);
        chk("abt_err", cfg_err, 1);
        chk("abt_done", cfg_done, 0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("abt_quiet_valid", cmd_valid, 0);
            chk("abt_quiet_done", cfg_done, 0);
            chk("abt_idle", cfg_ready, 1);
        end

        // Host SET_RED blocked during the sequence, forwarded after the gap
        repeat (3) tick();
        start_cfg(16'd1, 16'd2, 16'd3, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 1) cfg_req = 1'b0;
            if (k == 5) begin
                host_type  = CMD_SET_RED;
                host_data  = 16'd9;
                host_valid = 1'b1;
            end
            if (k == 13) host_valid = 1'b0;
            #1;
            if (k >= 5 && k <= 12) chk("blk_host_ready", host_ready, (k == 12) ? 1 : 0);
            if (k == 10) begin
                chk("blk_yellow_valid", cmd_valid, 1);
                chk("blk_yellow_type", cmd_type, CMD_SET_YELLOW);
                chk("blk_yellow_data", cmd_data, 3);
                chk("blk_done", cfg_done, 1);
            end
            if (k == 11 || k == 12) chk("blk_gap", cmd_valid, 0);
            if (k == 13) begin
                chk("blk_fwd_valid", cmd_valid, 1);
                chk("blk_fwd_type", cmd_type, CMD_SET_RED);
                chk("blk_fwd_data", cmd_data, 9);
            end
        end

        // Simultaneous host ON and cfg request
        repeat (3) tick();
        host_type  = CMD_ON;
        host_data  = 16'd0;
        host_valid = 1'b1;
        start_cfg(16'd11, 16'd12, 16'd13, 1'b0);
        #1;
        chk("sim_host_ready", host_ready, 1);
        chk("sim_cfg_ready", cfg_ready, 1);
        ev_q.delete();
        ev_q.push_back('{cyc: 1,  t: CMD_ON,          d: 16'd0,  done: 1'b0});
        ev_q.push_back('{cyc: 4,  t: CMD_MANUAL_MODE, d: 16'd0,  done: 1'b0});
        ev_q.push_back('{cyc: 7,  t: CMD_SET_GREEN,   d: 16'd11, done: 1'b0});
        ev_q.push_back('{cyc: 10, t: CMD_SET_RED,     d: 16'd12, done: 1'b0});
        ev_q.push_back('{cyc: 13, t: CMD_SET_YELLOW,  d: 16'd13, done: 1'b1});
        check_window("sim", 15, 14);

        // Reset asserted in the cycle SET_GREEN is scheduled
        repeat (3) tick();
        start_cfg(16'd4, 16'd5, 16'd6, 1'b1);
        tick();
        cfg_req = 1'b0;
        tick();
        tick();
        srst = 1'b1;
        tick();
        chk("mrst_valid", cmd_valid, 0);
        chk("mrst_type", cmd_type, 0);
        chk("mrst_data", cmd_data, 0);
        chk("mrst_ready", cfg_ready, 1);
        srst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            chk("mrst_quiet", cmd_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
